// File: rtl/ymux_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter in front of the yMux2 output path.
package ymux_arbiter_pkg;

   // Data width shared by yMux2 and the arbiter datapath.
   localparam int YMUX_W_DEF    = 2;
   // Beats a requester may push per grant before it is forced to rotate.
   localparam int MAX_BEATS_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT0 = 2'b01,
      ST_GRANT1 = 2'b10
   } arb_state_e;

   // Grant state that belongs to the given requester index.
   function automatic arb_state_e grant_state(input logic side);
      grant_state = side ? ST_GRANT1 : ST_GRANT0;
   endfunction

endpackage

// File: rtl/yMux2.sv
// Two-input W-bit multiplexer: z = c ? b : a.
module yMux2
   import ymux_arbiter_pkg::*;
#(
   parameter int SIZE = YMUX_W_DEF
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            c,
   output logic [SIZE-1:0] z
);

   // Per-bit select between the two data paths, no storage.
   always_comb begin
      if (c) begin
         z = b;
      end else begin
         z = a;
      end
   end

endmodule

// File: rtl/ymux_arbiter.sv
// Two-requester burst arbiter driving the select of a shared yMux2 path.
// Rotating priority pointer, per-grant beat limit, back-to-back hand-over.
module ymux_arbiter
   import ymux_arbiter_pkg::*;
#(
   parameter int W         = YMUX_W_DEF,
   parameter int MAX_BEATS = MAX_BEATS_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic         last0,
   input  logic         last1,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] z,
   output logic         sel,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy
);

   localparam int            CW      = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = '0;

   arb_state_e    state_q, state_d;
   logic          ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          own_req;
   logic          oth_req;
   logic          own_last;
   logic          beat_ok;
   logic          rel_now;
   logic [CW-1:0] cnt_inc;

   // Outputs decoded straight from the state flop so reset drops them at once.
   always_comb begin
      gnt0      = (state_q == ST_GRANT0);
      gnt1      = (state_q == ST_GRANT1);
      busy      = gnt0 | gnt1;
      sel       = gnt1;
      out_valid = (gnt0 & req0) | (gnt1 & req1);
   end

   // Shared output path: d0 when sel is low, d1 when sel is high.
   yMux2 #(.SIZE(W)) u_mux (
      .a (d0),
      .b (d1),
      .c (sel),
      .z (z)
   );

   // Next state, pointer and beat counter; release hands over to the waiting side first.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      own_req  = sel ? req1 : req0;
      oth_req  = sel ? req0 : req1;
      own_last = sel ? last1 : last0;
      beat_ok  = out_valid & out_ready;
      cnt_inc  = cnt_q + CNT_ONE;
      rel_now  = ~own_req | (beat_ok & (own_last | (cnt_inc == CNT_MAX)));
      case (state_q)
         ST_IDLE: begin
            cnt_d = CNT_ZERO;
            if (req0 & req1) begin
               state_d = grant_state(ptr_q);
            end else if (req0) begin
               state_d = ST_GRANT0;
            end else if (req1) begin
               state_d = ST_GRANT1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            if (rel_now) begin
               ptr_d = ~sel;
               cnt_d = CNT_ZERO;
               if (oth_req) begin
                  state_d = grant_state(~sel);
               end else if (own_req) begin
                  state_d = state_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (beat_ok) begin
               cnt_d = cnt_inc;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State, pointer and counter registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ymux_arbiter.sv
// Self-checking bench for ymux_arbiter: directed scenarios plus randomized traffic
// against a requester-level reference model.
module tb_ymux_arbiter;

   localparam int W  = 2;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1, last0, last1, out_ready;
   logic [W-1:0] d0, d1;
   logic         out_valid, sel, gnt0, gnt1, busy;
   logic [W-1:0] z;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: owner 0=nobody, 1=requester0, 2=requester1.
   int m_owner;
   int m_ptr;
   int m_cnt;

   ymux_arbiter #(.W(W), .MAX_BEATS(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .d0        (d0),
      .d1        (d1),
      .last0     (last0),
      .last1     (last1),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .z         (z),
      .sel       (sel),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0; out_ready = 1'b0;
      d0 = 2'b01; d1 = 2'b10;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_owner = 0; m_ptr = 0; m_cnt = 0;
   endtask

   // Advance the model by one rising edge using the current inputs.
   task automatic model_edge();
      int  me;
      bit  my_req, oth, my_last, acc;
      if (m_owner == 0) begin
         m_cnt = 0;
         if (req0 && req1) m_owner = m_ptr + 1;
         else if (req0)    m_owner = 1;
         else if (req1)    m_owner = 2;
      end else begin
         me      = m_owner - 1;
         my_req  = (me == 1) ? req1 : req0;
         oth     = (me == 1) ? req0 : req1;
         my_last = (me == 1) ? last1 : last0;
         acc     = my_req && out_ready;
         if (acc) m_cnt++;
         if (!my_req || (acc && (my_last || m_cnt == MB))) begin
            m_ptr = 1 - me;
            m_cnt = 0;
            if (oth)         m_owner = 2 - me;
            else if (my_req) m_owner = me + 1;
            else             m_owner = 0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
      #2;
      n_checks++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt0: got %b want 0", gnt0); else n_pass++;
      n_checks++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1: got %b want 0", gnt1); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (sel !== 1'b0) $display("FAIL reset_sel: got %b want 0", sel); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (z !== 2'b01) $display("FAIL reset_z: got %b want 01", z); else n_pass++;
      tick();
      n_checks++; if (gnt0 !== 1'b0) $display("FAIL reset_hold_gnt0: got %b want 0", gnt0); else n_pass++;
   endtask

   task automatic test_single_beat();
      do_reset();
      req0 = 1'b1; d0 = 2'b10; out_ready = 1'b1; last0 = 1'b1;
      #1;
      n_checks++; if (gnt0 !== 1'b0) $display("FAIL single_idle_gnt0: got %b want 0", gnt0); else n_pass++;
      tick();
      n_checks++; if (gnt0 !== 1'b1) $display("FAIL single_gnt0: got %b want 1", gnt0); else n_pass++;
      n_checks++; if (z !== 2'b10) $display("FAIL single_z: got %b want 10", z); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
      // Beat with last0 releases; drop the request so the grant goes idle.
      tick();
      req0 = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL single_release_busy: got %b want 0", busy); else n_pass++;
      // Pointer now favours requester 1.
      req0 = 1'b1; req1 = 1'b1; last0 = 1'b0;
      tick();
      n_checks++; if (gnt1 !== 1'b1) $display("FAIL single_ptr_gnt1: got %b want 1", gnt1); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1; last0 = 1'b0; d0 = 2'b00; d1 = 2'b11;
      tick();
      n_checks++; if (gnt0 !== 1'b1) $display("FAIL b2b_first_gnt0: got %b want 1", gnt0); else n_pass++;
      n_checks++; if (sel !== 1'b0) $display("FAIL b2b_first_sel: got %b want 0", sel); else n_pass++;
      last0 = 1'b1;
      tick();
      n_checks++; if (gnt1 !== 1'b1) $display("FAIL b2b_gnt1: got %b want 1", gnt1); else n_pass++;
      n_checks++; if (sel !== 1'b1) $display("FAIL b2b_sel: got %b want 1", sel); else n_pass++;
      n_checks++; if (z !== 2'b11) $display("FAIL b2b_z: got %b want 11", z); else n_pass++;
   endtask

   task automatic test_max_beats();
      int beats;
      do_reset();
      req1 = 1'b1; out_ready = 1'b1; last1 = 1'b0;
      tick();
      n_checks++; if (gnt1 !== 1'b1) $display("FAIL maxb_enter_gnt1: got %b want 1", gnt1); else n_pass++;
      req0 = 1'b1;
      beats = 0;
      for (int k = 0; k < 20 && gnt1 === 1'b1; k++) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) beats++;
         tick();
      end
      n_checks++; if (beats != MB) $display("FAIL maxb_beats: got %0d want %0d", beats, MB); else n_pass++;
      n_checks++; if (gnt0 !== 1'b1) $display("FAIL maxb_gnt0: got %b want 1", gnt0); else n_pass++;
   endtask

   task automatic test_stall();
      do_reset();
      req0 = 1'b1; req1 = 1'b1; out_ready = 1'b0; last0 = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (gnt0 !== 1'b1) $display("FAIL stall_gnt0_%0d: got %b want 1", k, gnt0); else n_pass++;
         n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid_%0d: got %b want 1", k, out_valid); else n_pass++;
         tick();
      end
      n_checks++; if (gnt0 !== 1'b1) $display("FAIL stall_hold_gnt0: got %b want 1", gnt0); else n_pass++;
      out_ready = 1'b1;
      tick();
      n_checks++; if (gnt1 !== 1'b1) $display("FAIL stall_release_gnt1: got %b want 1", gnt1); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      req1 = 1'b1; out_ready = 1'b1; last1 = 1'b0; d0 = 2'b01; d1 = 2'b10;
      tick();
      tick();
      n_checks++; if (gnt1 !== 1'b1) $display("FAIL areset_pre_gnt1: got %b want 1", gnt1); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (gnt1 !== 1'b0) $display("FAIL areset_gnt1: got %b want 0", gnt1); else n_pass++;
      n_checks++; if (sel !== 1'b0) $display("FAIL areset_sel: got %b want 0", sel); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (z !== 2'b01) $display("FAIL areset_z: got %b want 01", z); else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_checks++; if (gnt1 !== 1'b0) $display("FAIL areset_idle: got %b want 0", gnt1); else n_pass++;
      tick();
      n_checks++; if (gnt1 !== 1'b1) $display("FAIL areset_regrant: got %b want 1", gnt1); else n_pass++;
   endtask

   task automatic test_random();
      logic         e_g0, e_g1, e_v;
      logic [W-1:0] e_z;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            #1;
            m_owner = 0; m_ptr = 0; m_cnt = 0;
            n_checks++; if (busy !== 1'b0) $display("FAIL rand_reset_busy @%0d: got %b want 0", i, busy); else n_pass++;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end else begin
            req0      = ($urandom_range(0, 3) != 0);
            req1      = ($urandom_range(0, 3) != 0);
            last0     = ($urandom_range(0, 3) == 0);
            last1     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            d0        = W'($urandom);
            d1        = W'($urandom);
            #1;
            e_g0 = (m_owner == 1);
            e_g1 = (m_owner == 2);
            e_v  = (e_g0 && req0) || (e_g1 && req1);
            e_z  = e_g1 ? d1 : d0;
            n_checks++; if (gnt0 !== e_g0) $display("FAIL rand_gnt0 @%0d: got %b want %b", i, gnt0, e_g0); else n_pass++;
            n_checks++; if (gnt1 !== e_g1) $display("FAIL rand_gnt1 @%0d: got %b want %b", i, gnt1, e_g1); else n_pass++;
            n_checks++; if (sel !== e_g1) $display("FAIL rand_sel @%0d: got %b want %b", i, sel, e_g1); else n_pass++;
            n_checks++; if (busy !== (e_g0 | e_g1)) $display("FAIL rand_busy @%0d: got %b want %b", i, busy, e_g0 | e_g1); else n_pass++;
            n_checks++; if (out_valid !== e_v) $display("FAIL rand_valid @%0d: got %b want %b", i, out_valid, e_v); else n_pass++;
            n_checks++; if (z !== e_z) $display("FAIL rand_z @%0d: got %b want %b", i, z, e_z); else n_pass++;
            n_checks++; if ((gnt0 & gnt1) !== 1'b0) $display("FAIL rand_onehot @%0d: got %b want 0", i, gnt0 & gnt1); else n_pass++;
            model_edge();
            tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_max_beats();
      test_stall();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ymux_arbiter.md
YMUX_ARBITER -- requirements
Module: ymux_arbiter

Interface
REQ-001 Parameter: W, default 2, data width of each requester path and of z; fixed equal to the yMux2 width.
REQ-002 Parameter: MAX_BEATS, default 4, maximum accepted beats per grant before forced rotation; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0, req1  input  1 each  request from requester 0 / 1.
REQ-006 d0, d1  input  W each  data from requester 0 / 1.
REQ-007 last0, last1  input  1 each  final beat of burst from requester 0 / 1.
REQ-008 out_ready  input  1  downstream accepts beat this cycle.
REQ-009 out_valid  output  1  z carries a valid beat.
REQ-010 z  output  W  shared output; equals d1 when sel=1, else d0.
REQ-011 sel  output  1  select driven into the shared mux.
REQ-012 gnt0, gnt1  output  1 each  one-hot-or-zero grant indication.
REQ-013 busy  output  1  high in any grant state.

Function
REQ-014 FSM states: IDLE, GRANT0, GRANT1; gnt0=(state==GRANT0), gnt1=(state==GRANT1), busy=gnt0|gnt1, sel=(state==GRANT1).
REQ-015 z is combinational from sel, d0, d1; zero-cycle latency from d to z.
REQ-016 out_valid = (GRANT0 & req0) | (GRANT1 & req1); combinational, no registered delay.
REQ-017 Beat accepted when out_valid & out_ready on a rising edge; out_ready with out_valid low has no effect.
REQ-018 Priority pointer ptr (1 bit) names the favoured requester when both request.
REQ-019 IDLE: no request -> stay; exactly one request -> that grant next cycle; both -> grant to ptr; request-to-grant latency is 1 cycle.
REQ-020 Beat counter cnt: cleared on entry to any grant state, incremented per accepted beat, width ceil(log2(MAX_BEATS+1)).
REQ-021 Release condition in GRANTi: accepted beat with lasti=1, OR accepted beat bringing cnt to MAX_BEATS, OR reqi=0.
REQ-022 lasti is sampled only on an accepted beat; lasti on a non-accepted cycle is ignored.
REQ-023 On release of GRANTi: ptr <= other requester; if other requester requests that cycle -> go directly to its grant (no IDLE bubble); else if reqi still high -> re-enter GRANTi with cnt cleared; else -> IDLE.
REQ-024 In a grant state with no release condition, state, ptr and sel hold; requests from the non-granted side are not observed.
REQ-025 gnt0 and gnt1 never high simultaneously.

Reset
REQ-026 rst_n low forces asynchronously: state=IDLE, ptr=0, cnt=0, gnt0=gnt1=0, sel=0, busy=0, out_valid=0; z then follows d0.
REQ-027 Reset asserted mid-burst aborts the burst with no completion beat; after deassertion, first grant follows REQ-019 with ptr=0.

Structure
REQ-028 State encoding (IDLE/GRANT0/GRANT1) and MAX_BEATS default live in a shared package; W default is shared with yMux2.
REQ-029 Shared output path is an instance of the existing yMux2 sub-module, a=d0, b=d1, c=sel, z=z; FSM, pointer and counter live in ymux_arbiter.

Verification
REQ-030 Reset then req0=1, d0=2'b10, out_ready=1, last0=1 -> gnt0=1 one cycle later, z=2'b10, out_valid=1, release next edge, ptr=1.
REQ-031 From IDLE after reset, req0=req1=1 -> GRANT0 first (ptr=0); after last0 beat -> GRANT1 on the following cycle with no IDLE cycle, sel=1.
REQ-032 req1 held high, last1=0, out_ready=1, MAX_BEATS=4 -> exactly 4 accepted beats then forced release; with req0=1 grant moves to GRANT0.
REQ-033 GRANT0 with out_ready=0 and last0=1 for 3 cycles -> no release, cnt=0, gnt0 held; then out_ready=1 -> release on that edge.
REQ-034 rst_n pulsed low mid-burst in GRANT1 -> gnt1, sel, out_valid drop immediately without a clock edge; after release, req1 alone -> GRANT1 in 1 cycle.
REQ-035 Every cycle of every scenario: gnt0&gnt1=0, z=(sel?d1:d0), out_valid matches REQ-016.
